// File: rtl/hex_display_scanner.sv
// ---------------------------------------------------------------------------
// hex_display_scanner
//
// Purpose:
//    Shows a 32-bit value as 8 hexadecimal digits on a time-multiplexed,
//    common-anode 7-segment display (Nexys-style wiring, active-low anodes
//    and segments). The value is double-buffered: loads go into a shadow
//    register and only reach the displayed register at the end of a full
//    8-digit scan, so a value never changes partway through a frame.
//
// Parameters:
//    SCAN_DIV  clock cycles each digit stays lit (1 .. 2^20-1)
//
// Ports:
//    clk_i    in   1   system clock, rising edge
//    rst_i    in   1   asynchronous reset, active low
//    data_i   in   32  value to display
//    load_i   in   1   capture strobe, samples data_i whenever high
//    an_o     out  8   digit anodes, active low, an_o[0] = rightmost digit
//    seg_o    out  7   segments {g,f,e,d,c,b,a}, active low
//    frame_o  out  1   one-cycle pulse after each completed 8-digit scan
//
// Optional feature:
//    HEX_DISPLAY_LZ_BLANK_EN  when defined, leading zero digits (all digits
//    left of the most significant non-zero nibble) are blanked. Digit 0 is
//    always shown. Anode scanning is unaffected.
// ---------------------------------------------------------------------------
module hex_display_scanner #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] data_i,
   input  logic        load_i,
   output logic [7:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        frame_o
);

   localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

   logic [19:0] div_cnt;
   logic [2:0]  digit;
   logic [31:0] shadow;
   logic [31:0] disp;
   logic        pending;

   logic        tick;
   logic        wrap;
   logic [3:0]  cur_nibble;
   logic [6:0]  cur_seg;
   logic        digit_blank;

   // A tick ends the dwell time of the current digit; the tick on the last
   // digit is the frame boundary where the shadow value may be committed.
   assign tick = (div_cnt == DIV_LAST);
   assign wrap = tick && (digit == 3'd7);

   assign cur_nibble = disp[{digit, 2'b00} +: 4];

   // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
   always_comb begin
      cur_seg = 7'h7F;
      case (cur_nibble)
         4'h0: cur_seg = 7'h40;
         4'h1: cur_seg = 7'h79;
         4'h2: cur_seg = 7'h24;
         4'h3: cur_seg = 7'h30;
         4'h4: cur_seg = 7'h19;
         4'h5: cur_seg = 7'h12;
         4'h6: cur_seg = 7'h02;
         4'h7: cur_seg = 7'h78;
         4'h8: cur_seg = 7'h00;
         4'h9: cur_seg = 7'h10;
         4'hA: cur_seg = 7'h08;
         4'hB: cur_seg = 7'h03;
         4'hC: cur_seg = 7'h46;
         4'hD: cur_seg = 7'h21;
         4'hE: cur_seg = 7'h06;
         4'hF: cur_seg = 7'h0E;
         default: cur_seg = 7'h7F;
      endcase
   end

`ifdef HEX_DISPLAY_LZ_BLANK_EN
   // A digit is a leading zero when it and every digit to its left are zero.
   // Digit 0 never blanks so a zero value still reads as a single "0".
   always_comb begin
      digit_blank = 1'b0;
      case (digit)
         3'd1: digit_blank = (disp[31:4]  == 28'h0);
         3'd2: digit_blank = (disp[31:8]  == 24'h0);
         3'd3: digit_blank = (disp[31:12] == 20'h0);
         3'd4: digit_blank = (disp[31:16] == 16'h0);
         3'd5: digit_blank = (disp[31:20] == 12'h0);
         3'd6: digit_blank = (disp[31:24] == 8'h0);
         3'd7: digit_blank = (disp[31:28] == 4'h0);
         default: digit_blank = 1'b0;
      endcase
   end
`else
   assign digit_blank = 1'b0;
`endif

   // Dwell counter and digit selector. The digit index wraps naturally from
   // 7 back to 0 through the 3-bit adder.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         div_cnt <= 20'd0;
         digit   <= 3'd0;
      end else if (tick) begin
         div_cnt <= 20'd0;
         digit   <= digit + 3'd1;
      end else begin
         div_cnt <= div_cnt + 20'd1;
      end
   end

   // Double buffer. Loads land in the shadow and raise pending; at the frame
   // boundary the displayed value is refreshed. A load arriving exactly on
   // the boundary bypasses the shadow so it is not delayed by a whole frame.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         shadow  <= 32'h0;
         disp    <= 32'h0;
         pending <= 1'b0;
      end else if (wrap) begin
         if (load_i) begin
            disp    <= data_i;
            shadow  <= data_i;
            pending <= 1'b0;
         end else if (pending) begin
            disp    <= shadow;
            pending <= 1'b0;
         end
      end else if (load_i) begin
         shadow  <= data_i;
         pending <= 1'b1;
      end
   end

   // Registered outputs, always reflecting the state of the previous cycle
   // so the anode and segment patterns change together.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         an_o    <= 8'hFF;
         seg_o   <= 7'h7F;
         frame_o <= 1'b0;
      end else begin
         an_o    <= ~(8'h01 << digit);
         seg_o   <= digit_blank ? 7'h7F : cur_seg;
         frame_o <= wrap;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_hex_display_scanner
//
// Purpose:
//    Directed testbench for hex_display_scanner with SCAN_DIV=4 (one frame
//    is 32 cycles). Tracks the number of rising edges since reset release
//    to know which digit should be lit and where the frame pulses fall,
//    and compares every output against hand-written segment codes.
//    Honours HEX_DISPLAY_LZ_BLANK_EN for the expected blanking.
// ---------------------------------------------------------------------------
module tb_hex_display_scanner;

   localparam int SCAN_DIV = 4;
   localparam int FRAME    = 8 * SCAN_DIV;

   logic        clk_i;
   logic        rst_i;
   logic [31:0] data_i;
   logic        load_i;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        frame_o;

   int checks;
   int errors;
   int edge_cnt;

   // Hand-written active-low patterns for hex digits 0..F.
   logic [6:0] hex_seg [16];

   hex_display_scanner #(
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .data_i (data_i),
      .load_i (load_i),
      .an_o   (an_o),
      .seg_o  (seg_o),
      .frame_o(frame_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Expected segment code for digit d of a displayed value.
   function automatic logic [6:0] segFor(input logic [31:0] value, input int d);
      logic [31:0] upper;
      upper = value >> (4 * d);
`ifdef HEX_DISPLAY_LZ_BLANK_EN
      if (d > 0 && upper == 32'h0) return 7'h7F;
`endif
      return hex_seg[upper[3:0]];
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] an_exp,
                              input logic [6:0] seg_exp, input logic frame_exp);
      checks++;
      assert (an_o === an_exp) else begin
         errors++;
         $error("[TB] FAIL %s an_o=%h expected %h (edge %0d)", tag, an_o, an_exp, edge_cnt);
      end
      checks++;
      assert (seg_o === seg_exp) else begin
         errors++;
         $error("[TB] FAIL %s seg_o=%h expected %h (edge %0d)", tag, seg_o, seg_exp, edge_cnt);
      end
      checks++;
      assert (frame_o === frame_exp) else begin
         errors++;
         $error("[TB] FAIL %s frame_o=%b expected %b (edge %0d)", tag, frame_o, frame_exp, edge_cnt);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] data, input logic load);
      data_i = data;
      load_i = load;
   endtask

   // Advance n clocks; after each edge check which digit is lit, its
   // segments for the value expected on screen, and the frame pulse.
   task automatic runCycles(input string tag, input int n, input logic [31:0] shown);
      int d;
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         edge_cnt++;
         d = ((edge_cnt - 1) / SCAN_DIV) % 8;
         checkOutput(tag, ~(8'h01 << d), segFor(shown, d), (edge_cnt % FRAME) == 0);
      end
   endtask

   task automatic loadOnce(input string tag, input logic [31:0] value, input logic [31:0] shown);
      applyStimulus(value, 1'b1);
      runCycles(tag, 1, shown);
      applyStimulus(32'hDEADBEEF, 1'b0);
   endtask

   task automatic releaseReset();
      @(negedge clk_i);
      rst_i    = 1'b1;
      edge_cnt = 0;
   endtask

   initial begin
      hex_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      checks   = 0;
      errors   = 0;
      edge_cnt = 0;
      rst_i    = 1'b0;
      applyStimulus(32'hDEADBEEF, 1'b0);

      // Reset held across clock edges.
      @(posedge clk_i);
      #1;
      checkOutput("reset_hold", 8'hFF, 7'h7F, 1'b0);

      // Release, then two free-running frames of "0" with frame pulses.
      releaseReset();
      runCycles("first_after_reset", 1, 32'h0);
      runCycles("scan_timing", 63, 32'h0);

      // Load while digit 3 is lit; screen stays "0" until the boundary.
      runCycles("pre_load", 13, 32'h0);
      loadOnce("load_digit3", 32'h1234ABCD, 32'h0);
      runCycles("hold_until_frame", 18, 32'h0);
      runCycles("double_buffer", 32, 32'h1234ABCD);

      // Several loads in one frame: the last one wins.
      runCycles("idle", 5, 32'h1234ABCD);
      loadOnce("load_first", 32'h11111111, 32'h1234ABCD);
      runCycles("idle", 10, 32'h1234ABCD);
      loadOnce("load_second", 32'h22222222, 32'h1234ABCD);
      runCycles("idle", 15, 32'h1234ABCD);
      runCycles("last_wins", 31, 32'h22222222);

      // Load exactly on the wrap edge goes straight to the screen.
      loadOnce("load_on_wrap", 32'hFFFFFFFF, 32'h22222222);
      runCycles("wrap_load", 32, 32'hFFFFFFFF);

      // Pending load then an asynchronous reset between edges.
      runCycles("idle", 5, 32'hFFFFFFFF);
      loadOnce("load_pending", 32'h12345678, 32'hFFFFFFFF);
      runCycles("idle", 3, 32'hFFFFFFFF);
      #3;
      rst_i = 1'b0;
      #1;
      checkOutput("async_reset", 8'hFF, 7'h7F, 1'b0);
      @(posedge clk_i);
      #1;
      checkOutput("async_reset_hold", 8'hFF, 7'h7F, 1'b0);
      releaseReset();
      runCycles("pending_discarded", 64, 32'h0);

      // Values exercising leading-zero handling (plain decode without it).
      runCycles("idle", 5, 32'h0);
      loadOnce("load_a5", 32'h000000A5, 32'h0);
      runCycles("idle", 26, 32'h0);
      runCycles("show_a5", 37, 32'h000000A5);
      loadOnce("load_zero", 32'h00000000, 32'h000000A5);
      runCycles("idle", 26, 32'h000000A5);
      runCycles("show_zero", 37, 32'h0);
      loadOnce("load_msb", 32'h80000000, 32'h0);
      runCycles("idle", 26, 32'h0);
      runCycles("show_msb", 32, 32'h80000000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
